// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder: one full_adder plus carry FF, LSB first
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result fills from the top so the first (LSB) sum bit ends up in bit 0.
  assign res_next = {fa_sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      SUM    <= '0;
      COUT   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= CIN;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry  <= fa_cout;
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            SUM   <= res_next;
            COUT  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB at this edge
            OVF   <= carry ^ fa_cout;
`endif
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= DONE_S;
          end
        end
        DONE_S: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
